card_dealer: RTL and testbench

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_dealer_if.sv | 19 +
 rtl/card_dealer.sv | 92 +++++++++
 tb/tb_card_dealer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// card_dealer_if: request/response bundle between a card consumer and the card dealer
interface card_dealer_if;
  logic sem_embaralhar;
  logic pjogador;
  logic pdealer;
  logic embaralhar_ok;
  logic cartaok;
  logic [5:0] pts_jogador;
  logic [5:0] pts_dealer;
  logic [3:0] carta;
  modport master (
    output sem_embaralhar, pjogador, pdealer,
    input embaralhar_ok, cartaok, pts_jogador, pts_dealer, carta
  );
  modport slave (
    input sem_embaralhar, pjogador, pdealer,
    output embaralhar_ok, cartaok, pts_jogador, pts_dealer, carta
  );
endinterface

// File: rtl/card_dealer.sv
// card_dealer: fills a 52-card deck, LFSR Fisher-Yates shuffles it and deals scored cards
module card_dealer (
  input logic clock,
  input logic reset,
  card_dealer_if.slave bus
);
  typedef enum logic [2:0] {FILL, SHUFFLE, READY, ADD, ACK} state_t;
  state_t state_q, state_d;
  logic [3:0] deck_q [52];
  logic [5:0] idx_q, ptr_q, pts_j_q, pts_d_q, pts_new, j;
  logic [3:0] rank_q, carta_q, value;
  logic [15:0] lfsr_q;
  logic [2:0] ace_j_q, ace_d_q, ace_in, ace_out;
  logic [6:0] sum_raw, sum_adj;
  logic hand_q, accept, req, fix;
  always_comb begin
    j = lfsr_q[5:0];
    accept = j <= idx_q;
    req = bus.pjogador || bus.pdealer;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= FILL;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (idx_q == 6'd51) state_d = bus.sem_embaralhar ? READY : SHUFFLE;
      SHUFFLE: if (accept && idx_q == 6'd1) state_d = READY;
      READY: if (req) state_d = ADD;
      ADD: state_d = ACK;
      ACK: if (!req) state_d = READY;
      default: state_d = FILL;
    endcase
  end
  always_comb begin
    bus.cartaok = state_q == ACK;
    bus.embaralhar_ok = state_q == READY || state_q == ADD || state_q == ACK;
    bus.pts_jogador = pts_j_q;
    bus.pts_dealer = pts_d_q;
    bus.carta = carta_q;
  end
  // Soft aces count as 11 and give back 10 at most once per card dealt
  always_comb begin
    value = carta_q == 4'd1 ? 4'd11 : carta_q >= 4'd10 ? 4'd10 : carta_q;
    ace_in = (hand_q ? ace_d_q : ace_j_q) + {2'b0, carta_q == 4'd1};
    sum_raw = {1'b0, hand_q ? pts_d_q : pts_j_q} + {3'b0, value};
    fix = sum_raw > 7'd21 && ace_in != 3'd0;
    sum_adj = fix ? sum_raw - 7'd10 : sum_raw;
    ace_out = fix ? ace_in - 3'd1 : ace_in;
    pts_new = sum_adj > 7'd63 ? 6'd63 : sum_adj[5:0];
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      lfsr_q <= 16'hACE1;
      idx_q <= '0;
      rank_q <= 4'd1;
      ptr_q <= '0;
      carta_q <= '0;
      hand_q <= 1'b0;
      pts_j_q <= '0;
      pts_d_q <= '0;
      ace_j_q <= '0;
      ace_d_q <= '0;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      if (state_q == FILL) begin
        idx_q <= idx_q == 6'd51 ? idx_q : idx_q + 6'd1;
        rank_q <= rank_q == 4'd13 ? 4'd1 : rank_q + 4'd1;
      end
      if (state_q == SHUFFLE && accept) idx_q <= idx_q - 6'd1;
      if (state_q == READY && req) begin
        carta_q <= deck_q[ptr_q];
        ptr_q <= ptr_q == 6'd51 ? 6'd0 : ptr_q + 6'd1;
        hand_q <= !bus.pjogador;
      end
      if (state_q == ADD && !hand_q) begin
        pts_j_q <= pts_new;
        ace_j_q <= ace_out;
      end
      if (state_q == ADD && hand_q) begin
        pts_d_q <= pts_new;
        ace_d_q <= ace_out;
      end
    end
  // Deck contents need no reset: FILL rewrites every entry before use
  always_ff @(posedge clock)
    if (state_q == FILL) deck_q[idx_q] <= rank_q;
    else if (state_q == SHUFFLE && accept) begin
      deck_q[idx_q] <= deck_q[j];
      deck_q[j] <= deck_q[idx_q];
    end
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: vector table, randomized model comparison and shuffle/reset sequences
module tb_card_dealer;
  logic clock = 0;
  logic reset = 0;
  card_dealer_if bus();
  card_dealer dut (.clock(clock), .reset(reset), .bus(bus));
  always #10 clock = ~clock;
  int checks = 0, errors = 0;
  int m_pts[2], m_ace[2], m_n;
  typedef struct { logic [1:0] req; int hold; int carta; int pj; int pd; } vec_t;
  vec_t tbl[14];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_pts = '{0, 0};
    m_ace = '{0, 0};
    m_n = 0;
  endtask
  task automatic model_draw(input logic [1:0] req, output int rank);
    int h, v;
    h = req[0] ? 0 : 1;
    rank = m_n % 13 + 1;
    m_n++;
    v = rank == 1 ? 11 : (rank > 10 ? 10 : rank);
    if (rank == 1) m_ace[h]++;
    m_pts[h] += v;
    if (m_pts[h] > 21 && m_ace[h] > 0) begin
      m_pts[h] -= 10;
      m_ace[h]--;
    end
    if (m_pts[h] > 63) m_pts[h] = 63;
  endtask
  task automatic do_draw(input logic [1:0] req, input int hold, output int c, output int pj, output int pd);
    bit seen = 0;
    int held_bad = 0;
    bus.pjogador = req[0];
    bus.pdealer = req[1];
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      seen = bus.cartaok;
    end
    chk("draw_cartaok_seen", int'(seen), 1);
    c = bus.carta;
    pj = bus.pts_jogador;
    pd = bus.pts_dealer;
    chk("eok_stays_high", bus.embaralhar_ok, 1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      if (!bus.cartaok || bus.carta != c || bus.pts_jogador != pj || bus.pts_dealer != pd) held_bad++;
    end
    if (hold > 0) chk("held_request_no_redraw", held_bad, 0);
    bus.pjogador = 0;
    bus.pdealer = 0;
    @(negedge clock);
    chk("cartaok_falls", bus.cartaok, 0);
  endtask
  task automatic restart(input logic sem, input logic pend, input int maxcyc, output int cyc, output int ok_seen);
    bus.sem_embaralhar = sem;
    bus.pjogador = pend;
    bus.pdealer = 0;
    reset = 1;
    #1;
    chk("rst_cartaok", bus.cartaok, 0);
    chk("rst_eok", bus.embaralhar_ok, 0);
    chk("rst_pts_jogador", bus.pts_jogador, 0);
    chk("rst_pts_dealer", bus.pts_dealer, 0);
    chk("rst_carta", bus.carta, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    model_reset();
    cyc = 0;
    ok_seen = 0;
    for (int k = 1; k <= maxcyc; k++) begin
      @(negedge clock);
      ok_seen += bus.cartaok;
      if (bus.embaralhar_ok) begin
        cyc = k;
        break;
      end
    end
  endtask
  initial begin
    int cyc, cyc1, cyc2, oks, c, pj, pd, r, diff, cnt[14];
    int order[53];
    logic [1:0] rq;
    tbl = '{
      '{2'd1, 0, 1, 11, 0}, '{2'd2, 0, 2, 11, 2}, '{2'd1, 0, 3, 14, 2},
      '{2'd2, 0, 4, 14, 6}, '{2'd1, 0, 5, 19, 6}, '{2'd1, 10, 6, 15, 6},
      '{2'd1, 0, 7, 22, 6}, '{2'd3, 0, 8, 30, 6}, '{2'd2, 0, 9, 30, 15},
      '{2'd2, 0, 10, 30, 25}, '{2'd2, 2, 11, 30, 35}, '{2'd1, 0, 12, 40, 35},
      '{2'd1, 0, 13, 50, 35}, '{2'd2, 0, 1, 50, 36}};
    bus.sem_embaralhar = 1;
    bus.pjogador = 0;
    bus.pdealer = 0;
    #5;
    // Test mode, with a player request pending through the whole fill
    restart(1, 1, 200, cyc, oks);
    chk("fill_cycles_to_eok", cyc, 52);
    chk("no_cartaok_during_fill", oks, 0);
    foreach (tbl[i]) begin
      do_draw(tbl[i].req, tbl[i].hold, c, pj, pd);
      model_draw(tbl[i].req, r);
      chk("vec_carta", c, tbl[i].carta);
      chk("vec_pts_jogador", pj, tbl[i].pj);
      chk("vec_pts_dealer", pd, tbl[i].pd);
    end
    for (int i = 0; i < 60; i++) begin
      rq = 2'($urandom_range(1, 3));
      do_draw(rq, $urandom_range(0, 3), c, pj, pd);
      model_draw(rq, r);
      chk("rnd_carta", c, r);
      chk("rnd_pts_jogador", pj, m_pts[0]);
      chk("rnd_pts_dealer", pd, m_pts[1]);
    end
    // Reset while a card is being acknowledged
    bus.pjogador = 1;
    oks = 0;
    for (int k = 0; k < 20 && !oks; k++) begin
      @(negedge clock);
      oks = bus.cartaok;
    end
    chk("ack_reached_before_reset", oks, 1);
    #3;
    restart(0, 0, 4000, cyc1, oks);
    chk("shuffle_takes_longer_than_fill", int'(cyc1 > 52), 1);
    chk("no_cartaok_during_shuffle", oks, 0);
    cnt = '{default: 0};
    diff = 0;
    for (int i = 0; i < 53; i++) begin
      do_draw(2'd1, 0, c, pj, pd);
      order[i] = c;
      if (i < 52) begin
        if (c >= 1 && c <= 13) cnt[c]++;
        if (c != i % 13 + 1) diff++;
      end
    end
    for (int k = 1; k <= 13; k++) chk("rank_appears_4_times", cnt[k], 4);
    chk("draw53_wraps_to_first", order[52], order[0]);
    chk("deck_was_shuffled", int'(diff > 0), 1);
    // Abort a shuffle midway, then replay from reset: same history must give same deck
    restart(0, 0, 60, cyc, oks);
    restart(0, 0, 4000, cyc2, oks);
    chk("replay_ready_cycle", cyc2, cyc1);
    diff = 0;
    for (int i = 0; i < 52; i++) begin
      do_draw(2'd2, 0, c, pj, pd);
      if (c != order[i]) diff++;
    end
    chk("replay_same_deck_order", diff, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
